// File: rtl/link_error_monitor.sv
// Per-link BER monitor: saturating live bit/error counters with manual or
// windowed latching of results, threshold alarm and sticky saturation flag.
module link_error_monitor #(
  parameter int unsigned NLINKS        = 12,
  parameter int unsigned WORD_WIDTH    = 8,
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned WINDOW_WIDTH  = 24
) (
  input  logic                              clk,
  input  logic                              rstb,
  input  logic [NLINKS*WORD_WIDTH-1:0]      data_P,
  input  logic [NLINKS*WORD_WIDTH-1:0]      data_N,
  input  logic [NLINKS-1:0]                 data_valid,
  input  logic [NLINKS-1:0]                 counter_reset,
  input  logic                              global_counter_reset,
  input  logic [NLINKS-1:0]                 latch_counters,
  input  logic                              global_counter_latch,
  input  logic [NLINKS-1:0]                 window_mode,
  input  logic [WINDOW_WIDTH-1:0]           window_length,
  input  logic [COUNTER_WIDTH-1:0]          err_threshold,
  output logic [NLINKS*COUNTER_WIDTH-1:0]   bit_counter,
  output logic [NLINKS*COUNTER_WIDTH-1:0]   error_counter,
  output logic [NLINKS-1:0]                 window_done,
  output logic [NLINKS-1:0]                 err_alarm,
  output logic [NLINKS-1:0]                 saturated
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [COUNTER_WIDTH-1:0] CMAX = '1;

  function automatic logic [COUNTER_WIDTH-1:0] sat_add(
    input logic [COUNTER_WIDTH-1:0] a,
    input logic [COUNTER_WIDTH-1:0] b
  );
    logic [COUNTER_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COUNTER_WIDTH] ? CMAX : s[COUNTER_WIDTH-1:0];
  endfunction

  function automatic logic [COUNTER_WIDTH-1:0] popcount(input logic [WORD_WIDTH-1:0] x);
    logic [COUNTER_WIDTH-1:0] c;
    c = '0;
    for (int unsigned b = 0; b < WORD_WIDTH; b++) c = c + COUNTER_WIDTH'(x[b]);
    return c;
  endfunction

  for (genvar gi = 0; gi < NLINKS; gi++) begin : g_link
    state_t                    state_q, state_d;
    logic [COUNTER_WIDTH-1:0]  live_bits_q, live_bits_d, live_errs_q, live_errs_d;
    logic [COUNTER_WIDTH-1:0]  out_bits_q, out_bits_d, out_errs_q, out_errs_d;
    logic [WINDOW_WIDTH-1:0]   word_q, word_d;
    logic                      done_q, done_d, alarm_q, alarm_d, sat_q, sat_d;
    logic                      clr, valid, latch_req, enable;
    logic [COUNTER_WIDTH-1:0]  bits_inc, errs_inc;
    logic [WINDOW_WIDTH:0]     wc_inc;

    always_comb begin
      clr       = counter_reset[gi] | global_counter_reset;
      valid     = data_valid[gi];
      latch_req = latch_counters[gi] | global_counter_latch;
      enable    = window_mode[gi] && (window_length != '0);
      bits_inc  = sat_add(live_bits_q, COUNTER_WIDTH'(WORD_WIDTH));
      errs_inc  = sat_add(live_errs_q, popcount(data_P[gi*WORD_WIDTH +: WORD_WIDTH] ^
                                                data_N[gi*WORD_WIDTH +: WORD_WIDTH]));
      wc_inc    = {1'b0, word_q} + 1'b1;

      state_d     = state_q;
      live_bits_d = live_bits_q;
      live_errs_d = live_errs_q;
      out_bits_d  = out_bits_q;
      out_errs_d  = out_errs_q;
      word_d      = word_q;
      done_d      = 1'b0;
      alarm_d     = alarm_q;
      sat_d       = sat_q;

      if (valid) begin
        live_bits_d = bits_inc;
        live_errs_d = errs_inc;
        if (bits_inc == CMAX || errs_inc == CMAX) sat_d = 1'b1;
      end

      case (state_q)
        IDLE: begin
          // Manual latch takes the registered values; this cycle's word lands in live only.
          if (latch_req) begin
            out_bits_d = live_bits_q;
            out_errs_d = live_errs_q;
            alarm_d    = live_errs_q > err_threshold;
          end
          if (enable) state_d = RUN;
        end
        RUN: begin
          if (!enable) begin
            state_d = IDLE;
            word_d  = '0;
          end else if (valid) begin
            // >= so a shrunken window_length closes on the next valid word.
            if (wc_inc >= {1'b0, window_length}) begin
              out_bits_d  = bits_inc;
              out_errs_d  = errs_inc;
              alarm_d     = errs_inc > err_threshold;
              live_bits_d = '0;
              live_errs_d = '0;
              word_d      = '0;
              done_d      = 1'b1;
            end else begin
              word_d = wc_inc[WINDOW_WIDTH-1:0];
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (clr) begin
        state_d     = IDLE;
        live_bits_d = '0;
        live_errs_d = '0;
        out_bits_d  = '0;
        out_errs_d  = '0;
        word_d      = '0;
        done_d      = 1'b0;
        alarm_d     = 1'b0;
        sat_d       = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        state_q     <= IDLE;
        live_bits_q <= '0;
        live_errs_q <= '0;
        out_bits_q  <= '0;
        out_errs_q  <= '0;
        word_q      <= '0;
        done_q      <= 1'b0;
        alarm_q     <= 1'b0;
        sat_q       <= 1'b0;
      end else begin
        state_q     <= state_d;
        live_bits_q <= live_bits_d;
        live_errs_q <= live_errs_d;
        out_bits_q  <= out_bits_d;
        out_errs_q  <= out_errs_d;
        word_q      <= word_d;
        done_q      <= done_d;
        alarm_q     <= alarm_d;
        sat_q       <= sat_d;
      end
    end

    assign bit_counter[gi*COUNTER_WIDTH +: COUNTER_WIDTH]   = out_bits_q;
    assign error_counter[gi*COUNTER_WIDTH +: COUNTER_WIDTH] = out_errs_q;
    assign window_done[gi] = done_q;
    assign err_alarm[gi]   = alarm_q;
    assign saturated[gi]   = sat_q;
  end

endmodule

// File: tb/tb_link_error_monitor.sv
// Scoreboarded random + directed bench for link_error_monitor against an
// integer-arithmetic reference model of each link.
module tb_link_error_monitor;
  localparam int NL = 4, WW = 8, CW = 8, WINW = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic               clk = 1'b0, rstb = 1'b0;
  logic [NL*WW-1:0]   data_P = '0, data_N = '0;
  logic [NL-1:0]      data_valid = '0, counter_reset = '0, latch_counters = '0, window_mode = '0;
  logic               global_counter_reset = 1'b0, global_counter_latch = 1'b0;
  logic [WINW-1:0]    window_length = '0;
  logic [CW-1:0]      err_threshold = '0;
  logic [NL*CW-1:0]   bit_counter, error_counter;
  logic [NL-1:0]      window_done, err_alarm, saturated;

  // staged stimulus, applied at the falling edge by step()
  logic               s_rstb = 1'b0;
  logic [NL*WW-1:0]   s_P = '0, s_N = '0;
  logic [NL-1:0]      s_valid = '0, s_cr = '0, s_latch = '0, s_mode = '0;
  logic               s_gcr = 1'b0, s_gl = 1'b0;
  logic [WINW-1:0]    s_wl = '0;
  logic [CW-1:0]      s_thr = '0;

  int checks = 0, errors = 0;

  link_error_monitor #(.NLINKS(NL), .WORD_WIDTH(WW), .COUNTER_WIDTH(CW), .WINDOW_WIDTH(WINW)) dut (
    .clk(clk), .rstb(rstb), .data_P(data_P), .data_N(data_N), .data_valid(data_valid),
    .counter_reset(counter_reset), .global_counter_reset(global_counter_reset),
    .latch_counters(latch_counters), .global_counter_latch(global_counter_latch),
    .window_mode(window_mode), .window_length(window_length), .err_threshold(err_threshold),
    .bit_counter(bit_counter), .error_counter(error_counter), .window_done(window_done),
    .err_alarm(err_alarm), .saturated(saturated)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NL*CW-1:0] bits, errs;
    logic [NL-1:0]    done, alarm, sat;
  } exp_t;
  exp_t exp_q[$];

  // reference model state
  int m_live_b[NL], m_live_e[NL], m_words[NL], m_out_b[NL], m_out_e[NL];
  bit m_run[NL], m_done[NL], m_alarm[NL], m_sat[NL];

  function automatic int clamp(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_step();
    exp_t e;
    for (int l = 0; l < NL; l++) begin
      int  pop, nb, ne;
      bit  en, v;
      if (!rstb || counter_reset[l] || global_counter_reset) begin
        m_live_b[l] = 0; m_live_e[l] = 0; m_words[l] = 0; m_out_b[l] = 0; m_out_e[l] = 0;
        m_run[l] = 0; m_done[l] = 0; m_alarm[l] = 0; m_sat[l] = 0;
        continue;
      end
      m_done[l] = 0;
      en  = window_mode[l] && (window_length != 0);
      v   = data_valid[l];
      pop = $countones(data_P[l*WW +: WW] ^ data_N[l*WW +: WW]);
      nb  = clamp(m_live_b[l] + WW);
      ne  = clamp(m_live_e[l] + pop);
      if (v && (nb == CMAX || ne == CMAX)) m_sat[l] = 1;
      if (m_run[l]) begin
        if (!en) begin
          m_run[l] = 0; m_words[l] = 0;
          if (v) begin m_live_b[l] = nb; m_live_e[l] = ne; end
        end else if (v) begin
          m_words[l]++;
          if (m_words[l] >= int'(window_length)) begin
            m_out_b[l] = nb; m_out_e[l] = ne; m_alarm[l] = ne > int'(err_threshold);
            m_done[l] = 1; m_live_b[l] = 0; m_live_e[l] = 0; m_words[l] = 0;
          end else begin
            m_live_b[l] = nb; m_live_e[l] = ne;
          end
        end
      end else begin
        if (latch_counters[l] || global_counter_latch) begin
          m_out_b[l] = m_live_b[l]; m_out_e[l] = m_live_e[l];
          m_alarm[l] = m_live_e[l] > int'(err_threshold);
        end
        if (v) begin m_live_b[l] = nb; m_live_e[l] = ne; end
        if (en) m_run[l] = 1;
      end
    end
    for (int l = 0; l < NL; l++) begin
      e.bits[l*CW +: CW] = CW'(m_out_b[l]);
      e.errs[l*CW +: CW] = CW'(m_out_e[l]);
      e.done[l] = m_done[l]; e.alarm[l] = m_alarm[l]; e.sat[l] = m_sat[l];
    end
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    rstb = s_rstb; data_P = s_P; data_N = s_N; data_valid = s_valid;
    counter_reset = s_cr; global_counter_reset = s_gcr; latch_counters = s_latch;
    global_counter_latch = s_gl; window_mode = s_mode; window_length = s_wl; err_threshold = s_thr;
    model_step();
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic quiet();
    s_valid = '0; s_cr = '0; s_latch = '0; s_gcr = 1'b0; s_gl = 1'b0; s_P = '0; s_N = '0;
  endtask

  function automatic int lb(input int l); return int'(bit_counter[l*CW +: CW]); endfunction
  function automatic int le(input int l); return int'(error_counter[l*CW +: CW]); endfunction

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_bit_counter",   int'(bit_counter),   int'(e.bits));
        check("sb_error_counter", int'(error_counter), int'(e.errs));
        check("sb_window_done",   int'(window_done),   int'(e.done));
        check("sb_err_alarm",     int'(err_alarm),     int'(e.alarm));
        check("sb_saturated",     int'(saturated),     int'(e.sat));
      end
    end
  end

  initial begin
    for (int l = 0; l < NL; l++) begin
      m_live_b[l] = 0; m_live_e[l] = 0; m_words[l] = 0; m_out_b[l] = 0; m_out_e[l] = 0;
      m_run[l] = 0; m_done[l] = 0; m_alarm[l] = 0; m_sat[l] = 0;
    end
    #1;
    check("reset_bits", int'(bit_counter), 0);
    check("reset_flags", int'({window_done, err_alarm, saturated}), 0);
    step(); step();
    s_rstb = 1'b1; step();

    // manual: 10 words with two error bits each
    s_P[7:0] = 8'h03; s_valid[0] = 1'b1;
    repeat (10) step();
    quiet(); s_latch[0] = 1'b1; step();
    s_latch = '0;
    @(posedge clk); #1;
    check("man_bits", lb(0), 80);
    check("man_errs", le(0), 20);

    // windowed, length 4, all bits in error
    s_thr = 8'd31; s_wl = 6'd4; s_mode[1] = 1'b1; step();
    s_P[15:8] = 8'hFF; s_valid[1] = 1'b1;
    repeat (8) step();
    quiet();
    @(posedge clk); #1;
    check("win_bits", lb(1), 32);
    check("win_errs", le(1), 32);
    check("win_alarm", int'(err_alarm[1]), 1);
    check("win_done", int'(window_done[1]), 1);
    s_mode[1] = 1'b0; step();

    // saturation on link 3
    s_P[31:24] = 8'hFF; s_valid[3] = 1'b1;
    repeat (40) step();
    quiet(); s_latch[3] = 1'b1; step();
    s_latch = '0;
    @(posedge clk); #1;
    check("sat_errs", le(3), 255);
    check("sat_bits", lb(3), 255);
    check("sat_flag", int'(saturated[3]), 1);

    // clear beats latch and valid on link 2
    s_P[23:16] = 8'h0F; s_valid[2] = 1'b1; repeat (3) step();
    s_latch[2] = 1'b1; step();
    s_cr[2] = 1'b1; s_latch[2] = 1'b1; s_valid[2] = 1'b1; s_valid[0] = 1'b1; s_P[7:0] = 8'h01; step();
    quiet();
    @(posedge clk); #1;
    check("clr_bits2", lb(2), 0);
    check("clr_errs2", le(2), 0);
    check("clr_other3", lb(3), 255);

    // window abandoned mid-way then manual latch gives cumulative counts
    s_cr[1] = 1'b1; step(); quiet();
    s_thr = 8'd31; s_wl = 6'd4; s_mode[1] = 1'b1; step();
    s_P[15:8] = 8'hFF; s_valid[1] = 1'b1; repeat (2) step();
    quiet(); s_mode[1] = 1'b0; step();
    s_latch[1] = 1'b1; step(); s_latch = '0;
    @(posedge clk); #1;
    check("abort_bits", lb(1), 16);
    check("abort_errs", le(1), 16);
    check("abort_done", int'(window_done[1]), 0);

    // reset mid-window, then a fresh window from zero
    s_mode[1] = 1'b1; step();
    s_P[15:8] = 8'hFF; s_valid[1] = 1'b1; repeat (2) step();
    s_rstb = 1'b0; step(); #1;
    check("rst_async_bits", int'(bit_counter), 0);
    check("rst_async_errs", int'(error_counter), 0);
    s_rstb = 1'b1; quiet(); step(); step();
    s_P[15:8] = 8'hFF; s_valid[1] = 1'b1; repeat (4) step();
    quiet();
    @(posedge clk); #1;
    check("rst_restart_done", int'(window_done[1]), 1);
    check("rst_restart_bits", lb(1), 32);

    // randomized phase
    s_gcr = 1'b1; step(); quiet();
    for (int c = 0; c < 3000; c++) begin
      s_P = NL*WW'({$urandom, $urandom});
      s_N = s_P ^ NL*WW'({$urandom & $urandom & $urandom, $urandom & $urandom});
      s_valid = NL'($urandom);
      s_latch = '0; s_cr = '0;
      for (int l = 0; l < NL; l++) begin
        if ($urandom_range(19) == 0) s_mode[l] = ~s_mode[l];
        if ($urandom_range(3) == 0) s_latch[l] = 1'b1;
        if ($urandom_range(59) == 0) s_cr[l] = 1'b1;
      end
      if ($urandom_range(29) == 0) s_wl = WINW'($urandom_range(5));
      if ($urandom_range(49) == 0) s_thr = CW'($urandom);
      s_gcr  = ($urandom_range(199) == 0);
      s_gl   = ($urandom_range(19) == 0);
      s_rstb = ($urandom_range(299) != 0);
      step();
    end
    s_rstb = 1'b1; quiet(); step();

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/link_error_monitor.md
LINK_ERROR_MONITOR -- requirements
Module: link_error_monitor

Interface
REQ-001 SHALL have parameter NLINKS, default 12: number of independent links.
REQ-002 SHALL have parameter WORD_WIDTH, default 8: bits per deserialised word per link.
REQ-003 SHALL have parameter COUNTER_WIDTH, default 32: width of every bit/error counter.
REQ-004 SHALL have parameter WINDOW_WIDTH, default 24: width of window length / word counter.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  single clock for all logic.
REQ-006 rstb  in  1  asynchronous active-low reset.
REQ-007 data_P  in  NLINKS*WORD_WIDTH  P-side words, link i at bits [WORD_WIDTH*(i+1)-1 : WORD_WIDTH*i].
REQ-008 data_N  in  NLINKS*WORD_WIDTH  N-side (offset-delay) words, same packing.
REQ-009 data_valid  in  NLINKS  word on link i is valid this cycle.
REQ-010 counter_reset  in  NLINKS  per-link synchronous counter clear, level.
REQ-011 global_counter_reset  in  1  clears all links, level.
REQ-012 latch_counters  in  NLINKS  per-link latch request, manual mode.
REQ-013 global_counter_latch  in  1  latch request for all links, manual mode.
REQ-014 window_mode  in  NLINKS  0 = manual latch, 1 = automatic windowed latch.
REQ-015 window_length  in  WINDOW_WIDTH  valid words per window, shared by all links.
REQ-016 err_threshold  in  COUNTER_WIDTH  alarm threshold on latched error count.
REQ-017 bit_counter  out  NLINKS*COUNTER_WIDTH  latched bit counts.
REQ-018 error_counter  out  NLINKS*COUNTER_WIDTH  latched error counts.
REQ-019 window_done  out  NLINKS  one-cycle pulse when a window latch occurs.
REQ-020 err_alarm  out  NLINKS  latched error count > err_threshold.
REQ-021 saturated  out  NLINKS  sticky: a live counter hit all-ones since last clear.

Function
REQ-022 Each link SHALL hold live bit/error counters, a word counter and a 2-state FSM {IDLE, RUN}; links fully independent.
REQ-023 On a valid cycle live bit counter SHALL add WORD_WIDTH and live error counter SHALL add popcount(P xor N).
REQ-024 Live counters SHALL saturate at 2^COUNTER_WIDTH-1 (no wrap); reaching it sets saturated[i], cleared only by reset/clear.
REQ-025 Clear (counter_reset[i] or global_counter_reset) SHALL zero live, word and latched counters, err_alarm, saturated, and force IDLE, next edge; clear wins over latch, valid and window completion.
REQ-026 FSM: IDLE -> RUN when window_mode[i]=1 and window_length!=0; RUN -> IDLE when window_mode[i]=0 or window_length=0 (word counter zeroed on exit).
REQ-027 In IDLE (manual), a latch request SHALL copy the registered live values (excluding the same-cycle word) to outputs, visible one cycle later; live counting continues uninterrupted.
REQ-028 In RUN, latch requests SHALL be ignored; word counter increments per valid word.
REQ-029 In RUN, the valid word making word count equal window_length SHALL be included in the latch (live+increment, saturating); live and word counters restart at 0 the same edge; window_done pulses the next cycle coincident with new outputs.
REQ-030 window_length=1 SHALL latch every valid word; changing window_length mid-window SHALL compare against the new value; word count already >= new value completes on next valid word.
REQ-031 err_alarm SHALL update only when latched outputs update, as (new latched errors > err_threshold).
REQ-032 Latched outputs SHALL be stable between latch events.

Reset
REQ-033 While rstb=0 all counters, outputs, flags SHALL be 0 and FSMs IDLE, asynchronously; release synchronous to clk.
REQ-034 Reset asserted mid-window SHALL discard the partial window with no window_done pulse.

Verification
REQ-035 WORD_WIDTH=8, manual: 10 valid words, P^N=0x03 each, then latch -> bit_counter=80, error_counter=20 one cycle after latch.
REQ-036 Window: window_length=4, P^N=0xFF each, continuous valid -> window_done every 4th word, error_counter=32, bit_counter=32, err_threshold=31 gives err_alarm=1.
REQ-037 COUNTER_WIDTH=8: 40 valid words P^N=0xFF -> live error clamps at 255, saturated=1, latch gives 255 not wrapped.
REQ-038 Same cycle counter_reset[2], latch_counters[2], valid -> link 2 all zero next cycle, other links unaffected.
REQ-039 window_mode 1->0 mid-window with 2 of 4 words counted, then latch -> manual latch returns cumulative live counts, no window_done.
REQ-040 rstb low mid-window -> all outputs 0 immediately; after release window count restarts from 0.
